gemm_result_writer: RTL and testbench

// Write-back end of the GeMM result path. Accepts one finished C block per result_valid_i

---
 rtl/gemm_result_writer.sv | 137 +++++++++++++
 tb/tb_gemm_result_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_writer.sv
// Write-back stage of the GeMM result path: buffers finished C blocks in a small FIFO and
// writes each one to C SRAM at base + m*N + n, pulsing done_o once the whole job is committed.
module gemm_result_writer #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 256,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   M_size_i,
  input  logic [AddrWidth-1:0]   N_size_i,
  input  logic [AddrWidth-1:0]   base_i,
  input  logic                   result_valid_i,
  input  logic [DataWidth-1:0]   result_data_i,
  input  logic [AddrWidth-1:0]   m_idx_i,
  input  logic [AddrWidth-1:0]   n_idx_i,
  output logic                   result_ready_o,
  output logic                   sram_req_o,
  input  logic                   sram_gnt_i,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic [2*AddrWidth-1:0] written_cnt_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [AddrWidth-1:0]   n_size_q, n_size_d;
  logic [AddrWidth-1:0]   base_q, base_d;
  logic [2*AddrWidth-1:0] total_q, total_d;
  logic [2*AddrWidth-1:0] cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [PtrW:0]          wptr_q, wptr_d, rptr_q, rptr_d;

  logic [AddrWidth-1:0] addr_mem [FifoDepth];
  logic [DataWidth-1:0] data_mem [FifoDepth];

  logic                   empty, full, push, pop;
  logic [AddrWidth-1:0]   row_offs, push_addr;
  logic [2*AddrWidth-1:0] start_total;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  assign result_ready_o = (state_q == StDrain) && !full;
  assign push           = result_valid_i && result_ready_o;
  assign sram_req_o     = (state_q == StDrain) && !empty;
  assign sram_we_o      = sram_req_o;
  assign pop            = sram_req_o && sram_gnt_i;

  assign row_offs    = m_idx_i * n_size_q;
  assign push_addr   = base_q + row_offs + n_idx_i;
  assign start_total = {{AddrWidth{1'b0}}, M_size_i} * {{AddrWidth{1'b0}}, N_size_i};

  assign sram_addr_o   = sram_req_o ? addr_mem[rptr_q[PtrW-1:0]] : '0;
  assign sram_wdata_o  = sram_req_o ? data_mem[rptr_q[PtrW-1:0]] : '0;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign overflow_o    = ovf_q;
  assign written_cnt_o = cnt_q;

  always_comb begin
    state_d  = state_q;
    n_size_d = n_size_q;
    base_d   = base_q;
    total_d  = total_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wptr_d   = wptr_q + {{PtrW{1'b0}}, push};
    rptr_d   = rptr_q + {{PtrW{1'b0}}, pop};
    case (state_q)
      StIdle: begin
        if (start_i) begin
          n_size_d = N_size_i;
          base_d   = base_i;
          total_d  = start_total;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = (start_total == '0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (result_valid_i && !result_ready_o) ovf_d = 1'b1;
        if (pop) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == total_q) state_d = StDone;
        end
      end
      StDone: begin
        // Drop any unexpected leftovers so the next job starts empty.
        rptr_d  = wptr_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      n_size_q <= '0;
      base_q   <= '0;
      total_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
    end else begin
      state_q  <= state_d;
      n_size_q <= n_size_d;
      base_q   <= base_d;
      total_q  <= total_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wptr_q[PtrW-1:0]] <= push_addr;
      data_mem[wptr_q[PtrW-1:0]] <= result_data_i;
    end
  end

endmodule

// File: tb/tb_gemm_result_writer.sv
// Directed self-checking bench for gemm_result_writer: ordering, stalls, overflow,
// empty jobs, address wrap and mid-job reset.
module tb_gemm_result_writer;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [15:0]  M_size_i = '0;
  logic [15:0]  N_size_i = '0;
  logic [15:0]  base_i = '0;
  logic         result_valid_i = 1'b0;
  logic [255:0] result_data_i = '0;
  logic [15:0]  m_idx_i = '0;
  logic [15:0]  n_idx_i = '0;
  logic         result_ready_o;
  logic         sram_req_o;
  logic         sram_gnt_i = 1'b0;
  logic         sram_we_o;
  logic [15:0]  sram_addr_o;
  logic [255:0] sram_wdata_o;
  logic         busy_o;
  logic         done_o;
  logic         overflow_o;
  logic [31:0]  written_cnt_o;

  int errors = 0;
  int checks = 0;

  gemm_result_writer #(
    .AddrWidth(16),
    .DataWidth(256),
    .FifoDepth(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .M_size_i       (M_size_i),
    .N_size_i       (N_size_i),
    .base_i         (base_i),
    .result_valid_i (result_valid_i),
    .result_data_i  (result_data_i),
    .m_idx_i        (m_idx_i),
    .n_idx_i        (n_idx_i),
    .result_ready_o (result_ready_o),
    .sram_req_o     (sram_req_o),
    .sram_gnt_i     (sram_gnt_i),
    .sram_we_o      (sram_we_o),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o),
    .written_cnt_o  (written_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] dat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 + k;
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] b);
    start_i  = 1'b1;
    M_size_i = m;
    N_size_i = n;
    base_i   = b;
    tick();
    start_i  = 1'b0;
    M_size_i = 16'hDEAD;
    N_size_i = 16'hBEEF;
    base_i   = 16'h7777;
  endtask

  task automatic drive_result(input logic [15:0] m, input logic [15:0] n, input int k);
    result_valid_i = 1'b1;
    m_idx_i        = m;
    n_idx_i        = n;
    result_data_i  = dat(k);
  endtask

  initial begin
    logic [15:0] a;

    // Reset state
    tick();
    chk("rst_req", sram_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_ready", result_ready_o, 1'b0);
    chk("rst_cnt", written_cnt_o, 32'd0);
    chk("rst_addr", sram_addr_o, 16'd0);
    rst_ni = 1'b1;
    tick();

    // Job 1: M=2, N=3, base 0x100, gnt always high, row-major results
    sram_gnt_i = 1'b1;
    start_job(16'd2, 16'd3, 16'h0100);
    chk("j1_busy", busy_o, 1'b1);
    chk("j1_ready", result_ready_o, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive_result(16'(k / 3), 16'(k % 3), k);
      tick();
      result_valid_i = 1'b0;
      chk("j1_req", sram_req_o, 1'b1);
      chk("j1_we", sram_we_o, 1'b1);
      chk("j1_addr", sram_addr_o, 16'h0100 + 16'(k));
      chk("j1_data", sram_wdata_o, dat(k));
      chk("j1_done_early", done_o, 1'b0);
      tick();
      chk("j1_cnt", written_cnt_o, 32'(k + 1));
      chk("j1_done", done_o, k == 5);
    end
    tick();
    chk("j1_done_pulse", done_o, 1'b0);
    chk("j1_idle", busy_o, 1'b0);
    chk("j1_cnt_hold", written_cnt_o, 32'd6);

    // Job 2: M=1, N=4, gnt low while the FIFO fills, start while busy ignored
    sram_gnt_i = 1'b0;
    start_job(16'd1, 16'd4, 16'h0200);
    for (int k = 0; k < 4; k++) begin
      drive_result(16'd0, 16'(k), 10 + k);
      tick();
    end
    result_valid_i = 1'b0;
    chk("j2_full_ready", result_ready_o, 1'b0);
    chk("j2_req_held", sram_req_o, 1'b1);
    chk("j2_addr_held0", sram_addr_o, 16'h0200);
    start_i  = 1'b1;
    M_size_i = 16'd0;
    tick();
    start_i = 1'b0;
    chk("j2_start_ignored_busy", busy_o, 1'b1);
    chk("j2_start_ignored_done", done_o, 1'b0);
    chk("j2_addr_held1", sram_addr_o, 16'h0200);
    chk("j2_data_held1", sram_wdata_o, dat(10));
    chk("j2_cnt_stall", written_cnt_o, 32'd0);
    tick();
    chk("j2_addr_held2", sram_addr_o, 16'h0200);
    sram_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("j2_addr", sram_addr_o, 16'h0200 + 16'(k));
      chk("j2_data", sram_wdata_o, dat(10 + k));
      tick();
    end
    chk("j2_done", done_o, 1'b1);
    chk("j2_cnt", written_cnt_o, 32'd4);
    tick();
    chk("j2_done_pulse", done_o, 1'b0);

    // Job 3: overflow with gnt low, 5 back-to-back pulses into a depth-4 FIFO
    sram_gnt_i = 1'b0;
    start_job(16'd1, 16'd4, 16'h0300);
    for (int k = 0; k < 5; k++) begin
      drive_result(16'd0, 16'(k), 20 + k);
      #1;
      chk("j3_ready", result_ready_o, k < 4);
      tick();
    end
    result_valid_i = 1'b0;
    chk("j3_ovf", overflow_o, 1'b1);
    sram_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("j3_addr", sram_addr_o, 16'h0300 + 16'(k));
      chk("j3_data", sram_wdata_o, dat(20 + k));
      tick();
    end
    chk("j3_done", done_o, 1'b1);
    tick();
    chk("j3_ovf_sticky", overflow_o, 1'b1);
    chk("j3_idle", busy_o, 1'b0);

    // Job 4: empty job (M=0) finishes with no SRAM traffic, clears overflow
    start_job(16'd0, 16'd5, 16'h0400);
    chk("j4_done", done_o, 1'b1);
    chk("j4_req", sram_req_o, 1'b0);
    chk("j4_ovf_clr", overflow_o, 1'b0);
    chk("j4_cnt", written_cnt_o, 32'd0);
    tick();
    chk("j4_done_pulse", done_o, 1'b0);
    chk("j4_idle", busy_o, 1'b0);
    chk("j4_req2", sram_req_o, 1'b0);

    // Job 5: address wraps past 0xFFFF
    start_job(16'd1, 16'd4, 16'hFFFE);
    for (int k = 0; k < 4; k++) begin
      drive_result(16'd0, 16'(k), 30 + k);
      tick();
      result_valid_i = 1'b0;
      a = 16'hFFFE + 16'(k);
      chk("j5_addr", sram_addr_o, a);
      chk("j5_data", sram_wdata_o, dat(30 + k));
      tick();
    end
    chk("j5_done", done_o, 1'b1);
    tick();

    // Job 6: asynchronous reset with two entries queued, then a clean job
    sram_gnt_i = 1'b0;
    start_job(16'd1, 16'd4, 16'h0500);
    for (int k = 0; k < 2; k++) begin
      drive_result(16'd0, 16'(k), 50 + k);
      tick();
    end
    result_valid_i = 1'b0;
    chk("j6_req_pre", sram_req_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("j6_req_rst", sram_req_o, 1'b0);
    chk("j6_busy_rst", busy_o, 1'b0);
    chk("j6_ready_rst", result_ready_o, 1'b0);
    chk("j6_cnt_rst", written_cnt_o, 32'd0);
    chk("j6_addr_rst", sram_addr_o, 16'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("j6_req_after", sram_req_o, 1'b0);
    sram_gnt_i = 1'b1;
    start_job(16'd1, 16'd1, 16'h0040);
    drive_result(16'd0, 16'd0, 60);
    tick();
    result_valid_i = 1'b0;
    chk("j6_new_addr", sram_addr_o, 16'h0040);
    chk("j6_new_data", sram_wdata_o, dat(60));
    tick();
    chk("j6_new_done", done_o, 1'b1);
    chk("j6_new_cnt", written_cnt_o, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
